config_chain_ctrl: RTL and testbench

Sequences the logic block's configuration scan chain from the UART byte stream. Decodes a small command protocol and shifts payload bits LSB-first onto the chain head, one bit per SYSCLK. Captures the chain tail and echoes the displaced bits back over UART TX as readback. Sits between UART and LOGIC_BLOCK in place of a plain byte decoder. Holds user reset asserted while a load is in progress.

---
 rtl/config_chain_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_config_chain_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/config_chain_ctrl.sv
// config_chain_ctrl: decodes the UART command stream and drives the logic
// block's configuration scan chain. Payload bytes are shifted LSB-first onto
// the chain head while the displaced tail bits are echoed back over TX.
// Optional build macro CFG_CRC_EN: appends a CRC-8 (poly 0x07, init 0x00)
// of the payload after the last echo byte.
module config_chain_ctrl #(
    parameter int unsigned CHAIN_BYTES = 16,
    parameter logic [7:0]  CMD_WRITE   = 8'h01,
    parameter logic [7:0]  CMD_STATUS  = 8'h02
) (
    input  logic       SYSCLK,
    input  logic       SYSRST,
    input  logic       RX_VALID,
    input  logic [7:0] RX_DATA,
    input  logic       TX_READY,
    output logic       TX_VALID,
    output logic [7:0] TX_DATA,
    output logic       SHIFT_HEAD,
    input  logic       SHIFT_TAIL,
    output logic       SHIFT_ENABLE,
    output logic       USER_HOLD,
    output logic       BUSY,
    output logic       OVERRUN
);

    localparam int unsigned LEN_W  = 16;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [3:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        LOAD,
        SHIFT,
        ECHO,
        DONE,
        STAT,
        CRC_TX
    } state_t;

    state_t              state;
    logic [BYTE_W-1:0]   hold_data;
    logic                hold_full;
    logic [BYTE_W-1:0]   len_hi;
    logic [LEN_W-1:0]    cnt;
    logic [LEN_W-1:0]    last_len;
    logic [BYTE_W-2:0]   shreg;
    logic [BYTE_W-2:0]   rdreg;
    logic [2:0]          bit_cnt;

    logic take_c;
    logic stat_clr_c;
    logic len_mismatch_c;
    logic [LEN_W-1:0] len_new_c;

    // The decoder states and LOAD each consume the held byte when one is present
    assign take_c = hold_full && ((state == IDLE) || (state == LEN_HI) ||
                                  (state == LEN_LO) || (state == LOAD));
    assign stat_clr_c     = (state == STAT) && TX_VALID && TX_READY;
    assign len_mismatch_c = (last_len != LEN_W'(CHAIN_BYTES));
    assign len_new_c      = {len_hi, hold_data};

`ifdef CFG_CRC_EN
    logic [BYTE_W-1:0] crc;

    // One CRC-8 update over a whole byte, MSB first
    function automatic logic [BYTE_W-1:0] crc8_next(input logic [BYTE_W-1:0] c,
                                                    input logic [BYTE_W-1:0] d);
        logic [BYTE_W-1:0] r;
        r = c ^ d;
        for (int i = 0; i < 8; i++) begin
            r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
        end
        return r;
    endfunction
`endif

    // RX holding register and sticky overrun flag
    always_ff @(posedge SYSCLK or negedge SYSRST) begin
        if (!SYSRST) begin
            hold_data <= '0;
            hold_full <= 1'b0;
            OVERRUN   <= 1'b0;
        end else begin
            if (RX_VALID && !hold_full) begin
                hold_data <= RX_DATA;
                hold_full <= 1'b1;
            end else if (take_c) begin
                hold_full <= 1'b0;
            end
            if (RX_VALID && hold_full) begin
                OVERRUN <= 1'b1;
            end else if (stat_clr_c) begin
                OVERRUN <= 1'b0;
            end
        end
    end

    // Command sequencer with registered chain and TX outputs
    always_ff @(posedge SYSCLK or negedge SYSRST) begin
        if (!SYSRST) begin
            state        <= IDLE;
            BUSY         <= 1'b0;
            TX_VALID     <= 1'b0;
            TX_DATA      <= '0;
            SHIFT_HEAD   <= 1'b0;
            SHIFT_ENABLE <= 1'b0;
            USER_HOLD    <= 1'b0;
            len_hi       <= '0;
            cnt          <= '0;
            last_len     <= '0;
            shreg        <= '0;
            rdreg        <= '0;
            bit_cnt      <= '0;
`ifdef CFG_CRC_EN
            crc          <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (hold_full) begin
                        if (hold_data == CMD_WRITE) begin
                            state <= LEN_HI;
                            BUSY  <= 1'b1;
                        end else if (hold_data == CMD_STATUS) begin
                            state    <= STAT;
                            BUSY     <= 1'b1;
                            TX_VALID <= 1'b1;
                            TX_DATA  <= {OVERRUN, len_mismatch_c, 6'b0};
                        end
                    end
                end
                LEN_HI: begin
                    if (hold_full) begin
                        len_hi <= hold_data;
                        state  <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (hold_full) begin
                        last_len <= len_new_c;
                        cnt      <= len_new_c;
                        if (len_new_c == '0) begin
                            state <= IDLE;
                            BUSY  <= 1'b0;
                        end else begin
                            state     <= LOAD;
                            USER_HOLD <= 1'b1;
`ifdef CFG_CRC_EN
                            crc       <= '0;
`endif
                        end
                    end
                end
                LOAD: begin
                    if (hold_full) begin
                        shreg        <= hold_data[7:1];
                        SHIFT_HEAD   <= hold_data[0];
                        SHIFT_ENABLE <= 1'b1;
                        bit_cnt      <= '0;
                        state        <= SHIFT;
`ifdef CFG_CRC_EN
                        crc          <= crc8_next(crc, hold_data);
`endif
                    end
                end
                SHIFT: begin
                    // Tail bits enter at the top so the first one ends in bit 0
                    rdreg      <= {SHIFT_TAIL, rdreg[6:1]};
                    shreg      <= {1'b0, shreg[6:1]};
                    SHIFT_HEAD <= shreg[0];
                    bit_cnt    <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        SHIFT_ENABLE <= 1'b0;
                        SHIFT_HEAD   <= 1'b0;
                        TX_VALID     <= 1'b1;
                        TX_DATA      <= {SHIFT_TAIL, rdreg};
                        state        <= ECHO;
                    end
                end
                ECHO: begin
                    if (TX_READY) begin
                        TX_VALID <= 1'b0;
                        cnt      <= cnt - 16'd1;
                        state    <= (cnt == 16'd1) ? DONE : LOAD;
                    end
                end
                DONE: begin
`ifdef CFG_CRC_EN
                    TX_VALID <= 1'b1;
                    TX_DATA  <= crc;
                    state    <= CRC_TX;
`else
                    USER_HOLD <= 1'b0;
                    state     <= IDLE;
                    BUSY      <= 1'b0;
`endif
                end
`ifdef CFG_CRC_EN
                CRC_TX: begin
                    if (TX_READY) begin
                        TX_VALID  <= 1'b0;
                        USER_HOLD <= 1'b0;
                        state     <= IDLE;
                        BUSY      <= 1'b0;
                    end
                end
`endif
                STAT: begin
                    if (TX_READY) begin
                        TX_VALID <= 1'b0;
                        state    <= IDLE;
                        BUSY     <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_config_chain_ctrl.sv
// Bench for config_chain_ctrl: a bit-level chain model feeds SHIFT_TAIL, a
// byte-FIFO reference predicts echoes, and a monitor scoreboards TX and head bits.
module tb_config_chain_ctrl;

    localparam int unsigned CHAIN_BYTES = 16;
    localparam int unsigned CB          = CHAIN_BYTES * 8;

    logic       SYSCLK = 1'b0;
    logic       SYSRST;
    logic       RX_VALID;
    logic [7:0] RX_DATA;
    logic       TX_READY;
    logic       TX_VALID;
    logic [7:0] TX_DATA;
    logic       SHIFT_HEAD;
    logic       SHIFT_TAIL;
    logic       SHIFT_ENABLE;
    logic       USER_HOLD;
    logic       BUSY;
    logic       OVERRUN;

    config_chain_ctrl #(.CHAIN_BYTES(CHAIN_BYTES)) dut (
        .SYSCLK(SYSCLK), .SYSRST(SYSRST), .RX_VALID(RX_VALID), .RX_DATA(RX_DATA),
        .TX_READY(TX_READY), .TX_VALID(TX_VALID), .TX_DATA(TX_DATA),
        .SHIFT_HEAD(SHIFT_HEAD), .SHIFT_TAIL(SHIFT_TAIL), .SHIFT_ENABLE(SHIFT_ENABLE),
        .USER_HOLD(USER_HOLD), .BUSY(BUSY), .OVERRUN(OVERRUN)
    );

    always #5 SYSCLK = ~SYSCLK;

    // Physical chain: tail is bit 0, head bits enter at the top
    logic [CB-1:0] chain;
    logic [CB-1:0] preload_val;
    logic          preload_req = 1'b0;
    assign SHIFT_TAIL = chain[0];
    always @(posedge SYSCLK) begin
        if (preload_req) chain <= preload_val;
        else if (SHIFT_ENABLE) chain <= {SHIFT_HEAD, chain[CB-1:1]};
    end

    // Reference: the chain is a byte FIFO; scoreboard queues
    logic [7:0] chain_q[$];
    logic [7:0] exp_tx[$];
    logic [7:0] exp_head[$];
    logic [7:0] pl[16];
    bit         ovr_m  = 1'b0;
    int         last_m = 0;
    bit         stall  = 1'b0;

    int checks = 0;
    int passed = 0;
    int shift_cnt = 0;
    int tx_cnt = 0;
    bit hold_seen = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        logic fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[7] ^ d[i];
            r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return r;
    endfunction

    // TX_READY driver: random acceptance unless stalled
    initial begin
        TX_READY = 1'b0;
        forever begin
            @(negedge SYSCLK);
            TX_READY = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: scoreboard TX transfers and head bytes, check handshake invariants
    bit         prev_pend = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [7:0] acc = 8'h00;
    int         bitn = 0;
    always @(negedge SYSCLK) begin
        #1;
        if (!SYSRST) begin
            prev_pend = 1'b0;
            bitn = 0;
        end else begin
            if (prev_pend) begin
                chk("tx_valid_held", 32'(TX_VALID), 32'd1);
                chk("tx_data_stable", 32'(TX_DATA), 32'(prev_data));
            end
            if (TX_VALID && TX_READY) begin
                if (exp_tx.size() == 0) begin
                    checks++;
                    $display("FAIL tx_unexpected: got %02h with nothing expected at %0t", TX_DATA, $time);
                end else begin
                    chk("tx_byte", 32'(TX_DATA), 32'(exp_tx.pop_front()));
                end
                tx_cnt++;
            end
            prev_pend = TX_VALID && !TX_READY;
            prev_data = TX_DATA;
            if (SHIFT_ENABLE) begin
                chk("shift_while_tx", 32'(TX_VALID), 32'd0);
                chk("hold_during_shift", 32'(USER_HOLD), 32'd1);
                acc[bitn] = SHIFT_HEAD;
                bitn++;
                shift_cnt++;
                if (bitn == 8) begin
                    bitn = 0;
                    if (exp_head.size() == 0) begin
                        checks++;
                        $display("FAIL head_unexpected: got %02h with nothing expected", acc);
                    end else begin
                        chk("head_byte", 32'(acc), 32'(exp_head.pop_front()));
                    end
                end
            end
            if (USER_HOLD) hold_seen = 1'b1;
        end
    end

    task automatic preload(input logic [7:0] front);
        logic [CB-1:0] v;
        chain_q.delete();
        for (int i = 0; i < int'(CHAIN_BYTES); i++) begin
            v[i*8 +: 8] = (i == 0) ? front : 8'($urandom);
            chain_q.push_back(v[i*8 +: 8]);
        end
        @(negedge SYSCLK);
        preload_val = v;
        preload_req = 1'b1;
        @(negedge SYSCLK);
        preload_req = 1'b0;
    endtask

    // Strobe one byte, then leave two idle cycles
    task automatic send_byte(input logic [7:0] b);
        @(negedge SYSCLK);
        RX_VALID = 1'b1;
        RX_DATA  = b;
        @(negedge SYSCLK);
        RX_VALID = 1'b0;
        @(negedge SYSCLK);
    endtask

    task automatic wait_tx(input int target);
        int n = 0;
        while (tx_cnt < target && n < 3000) begin
            @(negedge SYSCLK);
            n++;
        end
        if (tx_cnt < target) timeout_fail("wait_tx");
    endtask

    task automatic wait_idle();
        int n = 0;
        while (BUSY && n < 5000) begin
            @(negedge SYSCLK);
            n++;
        end
        if (BUSY) timeout_fail("wait_idle");
        repeat (2) @(negedge SYSCLK);
    endtask

    // mode 0: normal, 1: TX stalled 50 cycles on first echo, 2: overrun injection
    task automatic do_write(input int n, input int mode);
        int sc0, t0, w;
        logic [7:0] crc;
        sc0 = shift_cnt;
        t0  = tx_cnt;
        crc = 8'h00;
        if (mode == 1) stall = 1'b1;
        send_byte(8'h01);
        send_byte(8'(n >> 8));
        send_byte(8'(n));
        for (int i = 0; i < n; i++) begin
            if (i >= 2) wait_tx(t0 + i - 1);
            exp_head.push_back(pl[i]);
            exp_tx.push_back(chain_q.pop_front());
            chain_q.push_back(pl[i]);
            crc = crc8(crc, pl[i]);
            send_byte(pl[i]);
            if (i == 0) begin
                #1 chk("first_shift_latency", 32'(SHIFT_ENABLE), 32'd1);
            end
            if (mode == 2 && i == 1) begin
                @(negedge SYSCLK);
                RX_VALID = 1'b1;
                RX_DATA  = 8'hEE;
                @(negedge SYSCLK);
                RX_DATA  = 8'hEF;
                @(negedge SYSCLK);
                RX_VALID = 1'b0;
                ovr_m = 1'b1;
                #1 chk("overrun_set", 32'(OVERRUN), 32'd1);
            end
        end
`ifdef CFG_CRC_EN
        exp_tx.push_back(crc);
`endif
        last_m = n;
        if (mode == 1) begin
            w = 0;
            while (!TX_VALID && w < 200) begin
                @(negedge SYSCLK);
                w++;
            end
            if (!TX_VALID) timeout_fail("first_echo");
            repeat (50) @(negedge SYSCLK);
            chk("no_shift_before_echo", 32'(shift_cnt - sc0), 32'd8);
            stall = 1'b0;
        end
        wait_idle();
        chk("shift_count", 32'(shift_cnt - sc0), 32'(8 * n));
        chk("user_hold_after", 32'(USER_HOLD), 32'd0);
    endtask

    task automatic do_status();
        logic [7:0] s;
        s = {ovr_m, last_m != int'(CHAIN_BYTES), 6'b0};
        exp_tx.push_back(s);
        ovr_m = 1'b0;
        send_byte(8'h02);
        wait_idle();
        chk("overrun_after_status", 32'(OVERRUN), 32'd0);
    endtask

    initial begin
        int sc0, t0, n;
        SYSRST   = 1'b0;
        RX_VALID = 1'b0;
        RX_DATA  = 8'h00;
        repeat (3) @(negedge SYSCLK);
        #1;
        chk("rst_tx_valid", 32'(TX_VALID), 32'd0);
        chk("rst_tx_data", 32'(TX_DATA), 32'd0);
        chk("rst_outputs", 32'({SHIFT_ENABLE, SHIFT_HEAD, USER_HOLD, BUSY, OVERRUN}), 32'd0);
        @(negedge SYSCLK);
        SYSRST = 1'b1;

        // Single byte: head A5 onto chain holding 3C at the tail
        preload(8'h3C);
        pl[0] = 8'hA5;
        do_write(1, 0);
        do_status();

        // Two bytes with a long TX stall on the first echo
        pl[0] = 8'h11;
        pl[1] = 8'h22;
        do_write(2, 1);

        // Zero length: nothing happens
        sc0 = shift_cnt;
        t0  = tx_cnt;
        hold_seen = 1'b0;
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h00);
        wait_idle();
        last_m = 0;
        chk("zero_shifts", 32'(shift_cnt - sc0), 32'd0);
        chk("zero_tx", 32'(tx_cnt - t0), 32'd0);
        chk("zero_hold", 32'(hold_seen), 32'd0);
        chk("zero_busy", 32'(BUSY), 32'd0);

        // Full-length write, status shows a match
        for (int i = 0; i < 16; i++) pl[i] = 8'($urandom);
        do_write(16, 0);
        do_status();

        // Overrun while shifting, then two status reads
        pl[0] = 8'($urandom);
        pl[1] = 8'($urandom);
        do_write(2, 2);
        do_status();
        do_status();

        // Random traffic with discarded junk commands
        for (int k = 0; k < 6; k++) begin
            send_byte(8'($urandom_range(3, 255)));
            #1 chk("junk_discard", 32'(BUSY), 32'd0);
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) pl[i] = 8'($urandom);
            do_write(n, 0);
            if ($urandom_range(0, 1) == 1) do_status();
        end

        // Asynchronous reset on the 4th shift of a write
        preload(8'h5A);
        sc0 = shift_cnt;
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'hC3);
        n = 0;
        while (shift_cnt < sc0 + 3 && n < 100) begin
            @(negedge SYSCLK);
            n++;
        end
        if (shift_cnt < sc0 + 3) timeout_fail("wait_fourth_shift");
        #3 SYSRST = 1'b0;
        #1;
        chk("async_rst_outputs",
            32'({TX_VALID, SHIFT_ENABLE, SHIFT_HEAD, USER_HOLD, BUSY, OVERRUN}), 32'd0);
        chk("async_rst_tx_data", 32'(TX_DATA), 32'd0);
        exp_tx.delete();
        exp_head.delete();
        ovr_m  = 1'b0;
        last_m = 0;
        preload(8'h00);
        @(negedge SYSCLK);
        SYSRST = 1'b1;
        do_status();

        repeat (5) @(negedge SYSCLK);
        chk("tx_queue_drained", 32'(exp_tx.size()), 32'd0);
        chk("head_queue_drained", 32'(exp_head.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
